// File: rtl/spi_master_param.sv
// SPI master: one DATA_W-bit full-duplex transfer per start; SPI mode and target slave are chosen per transfer.
// Latency: done pulses 1 + CLK_DIV*(2*DATA_W+2) cycles after the cycle in which start is accepted.
// Backpressure: start is taken only in IDLE; requests while busy (DONE included) are dropped, with no stall once started.

module spi_master_param #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 4,
  parameter int CS_SEL_W  = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        din,
  input  logic [1:0]               mode,
  input  logic [CS_SEL_W-1:0]      cs_sel,
  input  logic                     miso,
  output logic [2**CS_SEL_W-1:0]   cs,
  output logic                     sclk,
  output logic                     mosi,
  output logic [DATA_W-1:0]        dout,
  output logic                     busy,
  output logic                     done
);

  localparam int NUM_CS = 2**CS_SEL_W;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W   = $clog2(2*DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [HP_W-1:0]     hp_cnt;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;

  logic div_last, hp_last;
  logic accept, sclk_ev, sclk_lead, adv, smp, finish;

  // Bit that goes on the wire first / next, and the matching shift directions.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    first_bit = (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    shift_out = (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    shift_in = (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign div_last = (div_cnt == DIV_W'(CLK_DIV-1));
  assign hp_last  = (hp_cnt  == HP_W'(2*DATA_W-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: every timed phase ends on the last cycle of a CLK_DIV period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)              state_nxt = SETUP;
      SETUP:   if (div_last)           state_nxt = SHIFT;
      SHIFT:   if (div_last && hp_last) state_nxt = HOLD;
      HOLD:    if (div_last)           state_nxt = DONE;
      DONE:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Status outputs and per-cycle strobes; an sclk event fires on the cycle before the new half-period starts.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    accept    = (state == IDLE) && start;
    finish    = (state == HOLD) && div_last;
    sclk_ev   = ((state == SETUP) && div_last) || ((state == SHIFT) && div_last && !hp_last);
    // The coming toggle is a leading edge when sclk currently rests at CPOL.
    sclk_lead = (sclk == mode_q[1]);
    smp       = sclk_ev && (mode_q[0] ? !sclk_lead : sclk_lead);
    // CPHA=0 skips the trailing edge into the final half-period: all bits are already out.
    adv       = sclk_ev && (mode_q[0] ? sclk_lead
                                      : (!sclk_lead && (hp_cnt != HP_W'(2*DATA_W-2))));
  end

  // Divider counter: cycles within the current CLK_DIV period.
  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (state == SETUP || state == SHIFT || state == HOLD)
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    else
      div_cnt <= '0;
  end

  // Half-period counter across SHIFT.
  always_ff @(posedge clk) begin
    if (rst)
      hp_cnt <= '0;
    else if (state == SHIFT) begin
      if (div_last) hp_cnt <= hp_last ? '0 : hp_cnt + 1'b1;
    end else
      hp_cnt <= '0;
  end

  // Datapath: latch request, drive sclk/mosi, shift miso in, publish dout at DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs     <= '1;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      dout   <= '0;
      mode_q <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        cs     <= ~(NUM_CS'(1) << cs_sel);
        sclk   <= mode[1];
        rx_sh  <= '0;
        if (mode[0]) begin
          tx_sh <= din;
        end else begin
          // CPHA=0 needs the first bit on the wire before the first leading edge.
          tx_sh <= shift_out(din);
          mosi  <= first_bit(din);
        end
      end
      if (sclk_ev) sclk <= ~sclk;
      if (adv) begin
        mosi  <= first_bit(tx_sh);
        tx_sh <= shift_out(tx_sh);
      end
      if (smp) rx_sh <= shift_in(rx_sh, miso);
      if (finish) begin
        cs   <= '1;
        dout <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default instance with a mode-aware slave model, plus an LSB-first CLK_DIV=1 instance.
// Latency: checks done at T+105 (defaults) and T+27 (fast instance).
// Backpressure: exercises start while busy, start held through DONE, and reset mid-transfer.

module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic rst;

  // Default instance
  logic        start_a;
  logic [11:0] din_a;
  logic [1:0]  mode_a;
  logic [1:0]  sel_a;
  logic        miso_a;
  logic [3:0]  cs_a;
  logic        sclk_a, mosi_a;
  logic [11:0] dout_a;
  logic        busy_a, done_a;

  // LSB-first, CLK_DIV=1 instance, miso looped back
  logic        start_b;
  logic [11:0] din_b;
  logic [1:0]  mode_b;
  logic [1:0]  sel_b;
  logic [3:0]  cs_b;
  logic        sclk_b, mosi_b;
  logic [11:0] dout_b;
  logic        busy_b, done_b;

  spi_master_param dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .mode(mode_a), .cs_sel(sel_a),
    .miso(miso_a), .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a), .dout(dout_a),
    .busy(busy_a), .done(done_a)
  );

  spi_master_param #(.DATA_W(12), .CLK_DIV(1), .CS_SEL_W(2), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .mode(mode_b), .cs_sel(sel_b),
    .miso(mosi_b), .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .dout(dout_b),
    .busy(busy_b), .done(done_b)
  );

  // Slave model for the default instance (MSB first), evaluated mid-cycle.
  logic [1:0]  cur_mode   = 2'b00;
  logic        loop       = 1'b0;
  logic [11:0] slave_word = 12'h000;
  logic [11:0] s_tx = 12'h000;
  logic [11:0] s_rx = 12'h000;
  logic        miso_s = 1'b0;
  int          s_edges = 0;
  int          cs_chg = 0;
  logic [3:0]  prev_cs_a = 4'hF;
  logic        prev_sclk_a = 1'b0;

  assign miso_a = loop ? mosi_a : miso_s;

  always @(negedge clk) begin
    if (cs_a != 4'hF && prev_cs_a == 4'hF) begin
      s_edges <= 0;
      s_rx    <= 12'h000;
      if (!cur_mode[0]) begin
        miso_s <= slave_word[11];
        s_tx   <= slave_word << 1;
      end else begin
        s_tx   <= slave_word;
      end
    end else if (cs_a != 4'hF && sclk_a != prev_sclk_a) begin
      s_edges <= s_edges + 1;
      if ((sclk_a != cur_mode[1]) != cur_mode[0]) begin
        s_rx <= {s_rx[10:0], mosi_a};
      end else begin
        miso_s <= s_tx[11];
        s_tx   <= s_tx << 1;
      end
    end
    if (cs_a !== prev_cs_a) cs_chg <= cs_chg + 1;
    prev_cs_a   <= cs_a;
    prev_sclk_a <= sclk_a;
  end

  // Monitor for the fast instance (mode 01): record mosi on every falling (trailing) sclk edge.
  logic [11:0] b_seq = 12'h000;
  int          b_n = 0;
  int          b_edges = 0;
  logic [3:0]  prev_cs_b = 4'hF;
  logic        prev_sclk_b = 1'b0;

  always @(negedge clk) begin
    if (cs_b != 4'hF && prev_cs_b == 4'hF) begin
      b_n     <= 0;
      b_edges <= 0;
      b_seq   <= 12'h000;
    end else if (cs_b != 4'hF && sclk_b != prev_sclk_b) begin
      b_edges <= b_edges + 1;
      if (sclk_b == 1'b0 && b_n < 12) begin
        b_seq[11-b_n] <= mosi_b;
        b_n           <= b_n + 1;
      end
    end
    prev_cs_b   <= cs_b;
    prev_sclk_b <= sclk_b;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [11:0] din;
    logic        loop;
    logic [11:0] sword;
    logic [3:0]  exp_cs;
    logic [11:0] exp_dout;
    logic [11:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One transfer on the default instance; optional stray start pulses at T+10 and T+50.
  task automatic run_a(input string tag, input vec_t v, input bit pulses);
    int t0, chg0, lat, ndone;
    cur_mode   = v.mode;
    loop       = v.loop;
    slave_word = v.sword;
    @(negedge clk);
    start_a = 1'b1; din_a = v.din; mode_a = v.mode; sel_a = v.sel;
    t0 = cyc; chg0 = cs_chg; lat = -1; ndone = 0;
    for (int i = 1; i < 140; i++) begin
      @(negedge clk);
      start_a = pulses && (i == 10 || i == 50);
      if (i == 1) begin
        din_a = ~v.din; mode_a = ~v.mode; sel_a = ~v.sel;
      end
      if (i == 60) chk({tag, "_cs_low"}, cs_a, v.exp_cs);
      if (done_a) begin
        ndone++;
        if (lat < 0) lat = cyc - t0;
      end
    end
    start_a = 1'b0;
    chk({tag, "_latency"}, lat, 105);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_dout"}, dout_a, v.exp_dout);
    chk({tag, "_mosi_word"}, s_rx, v.exp_mosi);
    chk({tag, "_sclk_edges"}, s_edges, 24);
    chk({tag, "_cs_changes"}, cs_chg - chg0, 2);
    chk({tag, "_idle_sclk"}, sclk_a, v.mode[1]);
    chk({tag, "_idle_cs"}, cs_a, 4'hF);
    chk({tag, "_idle_busy"}, busy_a, 1'b0);
  endtask

  initial begin
    int t0, lat, dcnt, bcnt, n, last, run, min_gap;
    bit seen_low;

    vecs[0] = '{2'b00, 2'd0, 12'hABC, 1'b1, 12'h000, 4'b1110, 12'hABC, 12'hABC};
    vecs[1] = '{2'b11, 2'd2, 12'h123, 1'b0, 12'h5A5, 4'b1011, 12'h5A5, 12'h123};
    vecs[2] = '{2'b01, 2'd1, 12'h0F0, 1'b0, 12'h3C3, 4'b1101, 12'h3C3, 12'h0F0};
    vecs[3] = '{2'b10, 2'd3, 12'h800, 1'b0, 12'h001, 4'b0111, 12'h001, 12'h800};
    vecs[4] = '{2'b00, 2'd3, 12'hFFF, 1'b0, 12'h000, 4'b0111, 12'h000, 12'hFFF};
    vecs[5] = '{2'b11, 2'd0, 12'h001, 1'b0, 12'hFFE, 4'b1110, 12'hFFE, 12'h001};

    rst = 1'b1;
    start_a = 1'b0; din_a = 12'h000; mode_a = 2'b00; sel_a = 2'd0;
    start_b = 1'b0; din_b = 12'h000; mode_b = 2'b00; sel_b = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_a, 4'hF);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_mosi", mosi_a, 1'b0);
    chk("rst_dout", dout_a, 12'h000);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_b_cs", cs_b, 4'hF);
    chk("rst_b_busy", busy_b, 1'b0);
    rst = 1'b0;

    // Fast instance: LSB first, CLK_DIV=1, mode 01.
    @(negedge clk);
    start_b = 1'b1; din_b = 12'h123; mode_b = 2'b01; sel_b = 2'd1;
    t0 = cyc; lat = -1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start_b = 1'b0; din_b = 12'h000; mode_b = 2'b10; sel_b = 2'd0;
      end
      if (i == 5) chk("b_cs_low", cs_b, 4'b1101);
      if (done_b && lat < 0) lat = cyc - t0;
    end
    chk("b_latency", lat, 27);
    chk("b_mosi_order", b_seq, 12'b1100_0100_1000);
    chk("b_dout", dout_b, 12'h123);
    chk("b_sclk_edges", b_edges, 24);

    // Table-driven transfers on the default instance.
    for (int k = 0; k < 6; k++) run_a($sformatf("vec%0d", k), vecs[k], 1'b0);

    // Stray start pulses during a transfer.
    run_a("stray_start", vecs[2], 1'b1);

    // Reset mid-transfer, with start asserted in the reset cycle.
    cur_mode = vecs[0].mode; loop = vecs[0].loop; slave_word = vecs[0].sword;
    @(negedge clk);
    start_a = 1'b1; din_a = vecs[0].din; mode_a = vecs[0].mode; sel_a = vecs[0].sel;
    dcnt = 0; bcnt = 0;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (i == 40) begin
        rst = 1'b1; start_a = 1'b1;
      end
      if (i == 41) begin
        rst = 1'b0;
        chk("rst_mid_cs", cs_a, 4'hF);
        chk("rst_mid_sclk", sclk_a, 1'b0);
        chk("rst_mid_busy", busy_a, 1'b0);
        chk("rst_mid_dout", dout_a, 12'h000);
      end
      if (i > 41 && busy_a) bcnt++;
      if (done_a) dcnt++;
    end
    chk("rst_mid_no_done", dcnt, 0);
    chk("rst_mid_start_dropped", bcnt, 0);
    run_a("rst_recover", vecs[1], 1'b0);

    // Start held high for 300 cycles: back-to-back transfers.
    cur_mode = 2'b00; loop = 1'b1;
    @(negedge clk);
    start_a = 1'b1; din_a = 12'h5A3; mode_a = 2'b00; sel_a = 2'd1;
    t0 = cyc; n = 0; last = 0; run = 0; min_gap = 1000; seen_low = 1'b0;
    for (int i = 1; i <= 420; i++) begin
      @(negedge clk);
      if (i >= 300) start_a = 1'b0;
      if (done_a) begin
        n++;
        if (n == 1) chk("b2b_first_latency", cyc - t0, 105);
        else        chk("b2b_done_period", cyc - last, 106);
        chk("b2b_dout", dout_a, 12'h5A3);
        last = cyc;
      end
      if (cs_a == 4'hF) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen_low = 1'b1;
      end
    end
    chk("b2b_ndone", n, 3);
    chk("b2b_cs_gap_ok", (min_gap >= 1 && min_gap < 1000), 1'b1);
    chk("b2b_idle_busy", busy_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
